// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser, stability counter,
// clean level plus one-cycle edge pulses. Optional long-press pulse under DEBOUNCE_LONGPRESS_EN.
module debounce_multi #(
  parameter int CH          = 4,
  parameter int STABLE_CLKS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_CLKS   = 16
) (
  input  logic          clk50m,
  input  logic          rst_n,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] sw_dbnc,
  output logic [CH-1:0] sw_hi,
  output logic [CH-1:0] sw_lo,
  output logic [CH-1:0] sw_long
);

  localparam int               CNT_W    = $clog2(STABLE_CLKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CLKS - 1);

  if (CH < 1) begin : g_bad_ch
    $error("debounce_multi: CH must be >= 1");
  end
  if (STABLE_CLKS < 1) begin : g_bad_stable
    $error("debounce_multi: STABLE_CLKS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("debounce_multi: SYNC_STAGES must be >= 2");
  end
  if (LONG_CLKS < 1) begin : g_bad_long
    $error("debounce_multi: LONG_CLKS must be >= 1");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s_p0;
    logic [CNT_W-1:0]       cnt_p1;
    logic                   dbnc_p1;
    logic                   hi_p1;
    logic                   lo_p1;
    logic                   flip;

    // Stage 0: metastability chain, sw enters at bit 0
    always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
        sync_p0 <= '0;
      end else begin
        sync_p0 <= {sync_p0[SYNC_STAGES-2:0], sw[i]};
      end
    end

    assign s_p0 = sync_p0[SYNC_STAGES-1];
    assign flip = (s_p0 != dbnc_p1) && (cnt_p1 == CNT_LAST);

    // Stage 1: stability count; any agreement with the current level restarts it
    always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
        cnt_p1  <= '0;
        dbnc_p1 <= 1'b0;
        hi_p1   <= 1'b0;
        lo_p1   <= 1'b0;
      end else begin
        hi_p1 <= flip & ~dbnc_p1;
        lo_p1 <= flip &  dbnc_p1;
        if (s_p0 == dbnc_p1) begin
          cnt_p1 <= '0;
        end else if (flip) begin
          cnt_p1  <= '0;
          dbnc_p1 <= ~dbnc_p1;
        end else begin
          cnt_p1 <= cnt_p1 + CNT_W'(1);
        end
      end
    end

    assign sw_dbnc[i] = dbnc_p1;
    assign sw_hi[i]   = hi_p1;
    assign sw_lo[i]   = lo_p1;

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int                HOLD_W    = $clog2(LONG_CLKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CLKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CLKS);

    logic [HOLD_W-1:0] hold_p2;
    logic              long_p2;

    // Stage 2: hold timer saturates at LONG_CLKS so each press fires once
    always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
        hold_p2 <= '0;
        long_p2 <= 1'b0;
      end else begin
        long_p2 <= dbnc_p1 && (hold_p2 == HOLD_LAST);
        if (!dbnc_p1) begin
          hold_p2 <= '0;
        end else if (hold_p2 != HOLD_MAX) begin
          hold_p2 <= hold_p2 + HOLD_W'(1);
        end
      end
    end

    assign sw_long[i] = long_p2;
`else
    assign sw_long[i] = 1'b0;
`endif
  end

endmodule
